// File: rtl/disp_share_pkg.sv
// disp_share_pkg: shared width, state encoding and default dwell for the display scheduler
package disp_share_pkg;
    localparam int DISP_W = 16;
    localparam int DWELL_DEF = 5000000;
    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, URGENT = 2'd2} state_t;
endpackage

// File: rtl/disp_share_sched_rr_pick.sv
// rr_pick: first asserted request at or strictly after a start index, wrapping modulo N
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    input  logic         incl_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    logic [W-1:0] c;
    always_comb begin
        c = '0;
        idx_o = '0;
        found_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            c = W'((int'(start_i) + k + int'(!incl_i)) % N);
            if (req_i[c]) begin
                idx_o = c;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/disp_share_sched.sv
// disp_share_sched: round-robin/urgent time-sharing of one 16-bit display; DISP_SHARE_HOLD_EN adds a hold input that freezes the dwell
module disp_share_sched
    import disp_share_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = 2,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                      clk5,
    input  logic                      reset,
`ifdef DISP_SHARE_HOLD_EN
    input  logic                      hold,
`endif
    input  logic [DISP_W*N_SRC-1:0]   srcVal,
    input  logic [N_SRC-1:0]          srcReq,
    input  logic [N_SRC-1:0]          urgent,
    output logic [DISP_W-1:0]         dispVal,
    output logic [N_SRC-1:0]          grant,
    output logic [SRC_W-1:0]          srcSel,
    output logic [3:0]                dispDots
);
    localparam int CW = $clog2(DWELL);
    state_t st_q, st_d;
    logic [SRC_W-1:0] sel_q, sel_d, rr_q, rr_d, r_idx, u_idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N_SRC-1:0] req;
    logic r_found, u_found, frz;
`ifdef DISP_SHARE_HOLD_EN
    assign frz = hold;
`else
    assign frz = 1'b0;
`endif
    assign req = srcReq | urgent;
    assign srcSel = sel_q;
    rr_pick #(.N(N_SRC), .W(SRC_W)) u_rot (
        .req_i(req), .start_i(rr_q), .incl_i(st_q == IDLE), .idx_o(r_idx), .found_o(r_found)
    );
    rr_pick #(.N(N_SRC), .W(SRC_W)) u_urg (
        .req_i(urgent), .start_i('0), .incl_i(1'b1), .idx_o(u_idx), .found_o(u_found)
    );
    // rr_q always equals the shown source while in SHOW, so one rotation picker serves every case
    always_comb begin
        st_d = st_q;
        sel_d = sel_q;
        rr_d = rr_q;
        cnt_d = cnt_q;
        if (u_found) begin
            st_d = URGENT;
            sel_d = u_idx;
            cnt_d = '0;
        end else if (st_q != SHOW || !req[sel_q] || (cnt_q == CW'(DWELL - 1) && !frz)) begin
            st_d = r_found ? SHOW : IDLE;
            sel_d = r_found ? r_idx : '0;
            rr_d = r_found ? r_idx : rr_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(!frz);
        end
    end
    always_ff @(posedge clk5) begin
        if (reset) begin
            st_q <= IDLE;
            sel_q <= '0;
            rr_q <= '0;
            cnt_q <= '0;
            dispVal <= '0;
            grant <= '0;
            dispDots <= '0;
        end else begin
            st_q <= st_d;
            sel_q <= sel_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
            dispVal <= (st_d == IDLE) ? '0 : srcVal[sel_d*DISP_W +: DISP_W];
            grant <= (st_d == IDLE) ? '0 : N_SRC'(1) << sel_d;
            dispDots <= (st_d == IDLE) ? '0 : 4'd1 << 2'(sel_d);
        end
    end
endmodule

// File: tb/tb_disp_share_sched.sv
// tb_disp_share_sched: table-driven plan vectors plus random traffic against a rule-level model
module tb_disp_share_sched;
    localparam int N = 4;
    localparam int D = 4;
    logic clk5 = 1'b0;
    logic reset = 1'b1;
    logic hold = 1'b0;
    logic [63:0] srcVal;
    logic [3:0] srcReq = '0, urgent = '0;
    logic [15:0] dispVal;
    logic [3:0] grant, dispDots;
    logic [1:0] srcSel;
    int total = 0, bad = 0;
    int m_mode = 0, m_cur = 0, m_rr = 0, m_cnt = 0;
    logic [15:0] m_val = '0;
    typedef struct {
        logic rst;
        logic [3:0] req;
        logic [3:0] urg;
        logic [3:0] g;
        logic [15:0] v;
        int n;
    } vec_t;
    vec_t tbl[$];

    always #5 clk5 = ~clk5;

    disp_share_sched #(.N_SRC(N), .SRC_W(2), .DWELL(D)) dut (
        .clk5(clk5),
        .reset(reset),
`ifdef DISP_SHARE_HOLD_EN
        .hold(hold),
`endif
        .srcVal(srcVal),
        .srcReq(srcReq),
        .urgent(urgent),
        .dispVal(dispVal),
        .grant(grant),
        .srcSel(srcSel),
        .dispDots(dispDots)
    );

    function automatic int first_req(logic [3:0] r, int start, bit incl);
        for (int k = 0; k < N; k++) begin
            int c = (start + k + (incl ? 0 : 1)) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] r = srcReq | urgent;
        int n;
        if (reset) begin
            m_mode = 0; m_cur = 0; m_rr = 0; m_cnt = 0;
            return;
        end
        if (urgent != 0) begin
            m_mode = 2; m_cur = first_req(urgent, 0, 1); m_cnt = 0;
            return;
        end
        if (m_mode == 1 && r[m_cur] && !(m_cnt == D - 1 && !hold)) begin
            m_cnt += hold ? 0 : 1;
            return;
        end
        n = first_req(r, m_rr, m_mode == 0);
        m_cnt = 0;
        if (n < 0) begin
            m_mode = 0; m_cur = 0;
        end else begin
            m_mode = 1; m_cur = n; m_rr = n;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk5);
        model_step();
        m_val = (m_mode != 0) ? srcVal[m_cur*16 +: 16] : 16'h0;
        #1;
        check("model_val", 32'(dispVal), 32'(m_val));
        check("model_grant", 32'(grant), (m_mode != 0) ? 32'(1) << m_cur : 32'd0);
        check("model_sel", 32'(srcSel), (m_mode != 0) ? 32'(m_cur) : 32'd0);
        check("model_dots", 32'(dispDots), (m_mode != 0) ? 32'(1) << m_cur : 32'd0);
    endtask

    initial begin
        srcVal = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 16'h0000, 1});
        tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 10});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h1, 16'h1111, 4});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h4, 16'h3333, 4});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h1, 16'h1111, 3});
        tbl.push_back('{1'b0, 4'h5, 4'h8, 4'h8, 16'h4444, 3});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h4, 16'h3333, 4});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h1, 16'h1111, 4});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h4, 16'h3333, 2});
        tbl.push_back('{1'b1, 4'h5, 4'h0, 4'h0, 16'h0000, 1});
        tbl.push_back('{1'b0, 4'h5, 4'h0, 4'h1, 16'h1111, 1});
        tbl.push_back('{1'b0, 4'h2, 4'h0, 4'h2, 16'h2222, 12});
        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                reset = tbl[i].rst;
                srcReq = tbl[i].req;
                urgent = tbl[i].urg;
                cyc();
                check($sformatf("vec%0d.%0d_grant", i, j), 32'(grant), 32'(tbl[i].g));
                check($sformatf("vec%0d.%0d_val", i, j), 32'(dispVal), 32'(tbl[i].v));
            end
        end
        reset = 1'b0;
        srcReq = 4'b0100;
        for (int k = 0; k < 10 && grant !== 4'b0100; k++) cyc();
        check("reach_src2", 32'(grant), 32'h4);
        srcVal[47:32] = 16'hBEEF;
        cyc();
        check("live_beef", 32'(dispVal), 32'hBEEF);
`ifdef DISP_SHARE_HOLD_EN
        hold = 1'b1;
        srcReq = 4'b0110;
        for (int k = 0; k < 20; k++) begin
            cyc();
            check("hold_grant", 32'(grant), 32'h4);
        end
        hold = 1'b0;
`endif
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) srcReq = 4'($urandom);
            if ($urandom_range(0, 19) == 0) urgent = 4'($urandom) & 4'($urandom);
            else if ($urandom_range(0, 3) == 0) urgent = '0;
            if ($urandom_range(0, 5) == 0) srcVal[$urandom_range(0, 3)*16 +: 16] = 16'($urandom);
`ifdef DISP_SHARE_HOLD_EN
            if ($urandom_range(0, 9) == 0) hold = ~hold;
`endif
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/disp_share_sched.md
Name: disp_share_sched

Overview:
Time-shares the single 16-bit hex display among N requesting sources.
- Round-robin rotation: each requesting source is shown for a programmable dwell time.
- Urgent preemption: an urgent source takes the display immediately.
- Sits between the value producers and the display interface; its dispVal output drives the display's 16-bit input directly.

Parameters:
- N_SRC, 4, number of requesting sources (2..8)
- SRC_W, 2, width of source index; must equal ceil(log2(N_SRC))
- DWELL, 5000000, clk5 cycles per source slot (1 s at 5 MHz); must be >= 2

Ports:
- clk5  input  1  5 MHz system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- srcVal  input  16*N_SRC  packed source values; source i occupies bits [16*i+15:16*i]
- srcReq  input  N_SRC  source i wants display time
- urgent  input  N_SRC  source i demands immediate, exclusive display
- dispVal  output  16  registered value to display
- grant  output  N_SRC  one-hot, registered; source currently shown; all-zero when idle
- srcSel  output  SRC_W  index of current source; 0 when idle
- dispDots  output  4  registered one-hot of srcSel[1:0] (drives decimal points); 0 when idle

Behaviour:
- Reset: state IDLE, dispVal=16'h0000, grant=0, srcSel=0, dispDots=0, dwell counter=0, rr pointer=0. Reset applies mid-dwell or mid-urgent with identical result.
- Effective request: req_i = srcReq_i | urgent_i.
- State IDLE:
  - Any urgent bit set -> go to URGENT with the lowest-index urgent source.
  - Otherwise any req_i set -> go to SHOW with the first requester at or after the rr pointer (wrapping modulo N_SRC).
- State SHOW:
  - Dwell counter increments each cycle.
  - Any urgent bit set -> URGENT next cycle. Urgent overrides all other events the same cycle.
  - Else current source drops req -> switch to the next requester after current (wrapping); IDLE if none.
  - Else counter == DWELL-1 -> switch to the next requester strictly after current (wrapping). If current is the only requester, stay on it and reload.
  - Every switch or reload clears the counter to 0.
- State URGENT:
  - Shows the lowest-index asserted urgent source; the selection is re-evaluated every cycle.
  - Dwell counter is held at 0.
  - When no urgent bit remains: go to SHOW with the first requester after the last rotation source; IDLE if none.
- Rr pointer updates only on SHOW transitions; URGENT does not disturb rotation order.
- Datapath:
  - dispVal <= srcVal slice of the next selected source. Latency is 1 cycle from selection and from any srcVal change, so the shown value tracks a live source.
  - In IDLE, dispVal holds 16'h0000.
- grant, srcSel and dispDots change in the same cycle as dispVal.
- Index arithmetic is modulo N_SRC; the counter is wide enough for DWELL-1 (ceil(log2(DWELL)) bits).

Optional Feature:
- Macro DISP_SHARE_HOLD_EN adds input port `hold` (1 bit).
- With the macro: while hold=1 in SHOW, the dwell counter freezes and no dwell-expiry switch occurs. Request-drop and urgent transitions still occur.
- Without the macro: no hold port; dwell always advances.

Decomposition:
- Package disp_share_pkg holds:
  - DISP_W=16
  - state encoding IDLE=2'd0, SHOW=2'd1, URGENT=2'd2
  - default DWELL constant
- Sub-module rr_pick (combinational): given req vector, start index and an "inclusive" flag, returns next requester index plus a found flag. It is instantiated twice: rotation pick and lowest-urgent pick (start=0, inclusive).

Test Plan (DWELL=4, N_SRC=4, srcVal_i=16'h1111*(i+1)):
- Reset with srcReq=4'b0000 -> dispVal=0000, grant=0000, all outputs remain 0 for 10 cycles.
- srcReq=4'b0101 -> grant 0001 (dispVal 1111) for 4 cycles, then 0100 (3333) for 4, then 0001 again. Check exact switch cycle.
- srcReq=4'b0010 only -> grant stays 0010 indefinitely, dispVal=2222; counter reloads every 4 cycles with no glitch.
- Rotating on source 0 at count 2, assert urgent=4'b1000 for 3 cycles -> next cycle grant=1000, dispVal=4444. After urgent drops, grant=0100 (rotation resumes after source 0), counter starts at 0.
- Assert reset while grant=0100 mid-dwell -> next cycle all outputs 0, state IDLE; rotation restarts from source 0.
- Change srcVal_2 to 16'hBEEF while source 2 is shown -> dispVal=BEEF exactly 1 cycle later. With DISP_SHARE_HOLD_EN and hold=1, no switch occurs for 20 cycles.
